branch_cond_unit: RTL and testbench

Parametrised successor to the control unit's condition unit. It holds NUM_BANKS registered NZCV flag sets and evaluates all sixteen 4-bit condition codes against a selected bank. Branch requests use a valid/ready handshake and resolve with a registered one-cycle result. A taken branch drives a fixed-length pipeline flush, during which no new branch is accepted. It sits between the decoder's branch field and the PC-write path of the control unit.

---
 rtl/branch_cond_unit_pkg.sv | 32 +++
 rtl/branch_cond_unit_if.sv | 30 +++
 rtl/branch_cond_unit_cond_eval.sv | 43 ++++
 rtl/branch_cond_unit.sv | 148 ++++++++++++++
 tb/tb_branch_cond_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_cond_unit_pkg.sv
// ---------------------------------------------------------------------------
// cond_pkg: shared types and constants for the branch condition unit.
//   cond_e      : the sixteen 4-bit branch condition codes
//   N/Z/C/V_IDX : bit positions of each flag inside a {N,Z,C,V} nibble
//   state_e     : branch FSM states
//   calc_bank_w : bank-select width for a given bank count (never below 1)
// ---------------------------------------------------------------------------
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    function automatic int calc_bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/branch_cond_unit_if.sv
// ---------------------------------------------------------------------------
// branch_cond_unit_if: branch request handshake and result bundle.
//   br_valid/br_ready        : request handshake (accept = valid & ready)
//   br_cond/br_bank/wpc_en   : request payload, sampled at acceptance
//   taken_valid_o/taken_o    : one-cycle result pulse
//   flush_o                  : pipeline flush request after a taken branch
// master = requester (decoder side), slave = branch_cond_unit.
// ---------------------------------------------------------------------------
interface branch_cond_unit_if #(
    parameter int BANK_W = 1
);
    logic              br_valid;
    logic              br_ready;
    logic [3:0]        br_cond;
    logic [BANK_W-1:0] br_bank;
    logic              wpc_en;
    logic              taken_valid_o;
    logic              taken_o;
    logic              flush_o;

    modport master (
        output br_valid, br_cond, br_bank, wpc_en,
        input  br_ready, taken_valid_o, taken_o, flush_o
    );

    modport slave (
        input  br_valid, br_cond, br_bank, wpc_en,
        output br_ready, taken_valid_o, taken_o, flush_o
    );
endinterface

// File: rtl/branch_cond_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval: purely combinational condition-code evaluator.
//   cond_i  : condition code
//   flags_i : {N,Z,C,V}
//   pass_o  : 1 when the condition holds for the given flags
// ---------------------------------------------------------------------------
module cond_eval
    import cond_pkg::*;
(
    input  cond_e      cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);
    logic n, z, c, v;

    assign n = flags_i[N_IDX];
    assign z = flags_i[Z_IDX];
    assign c = flags_i[C_IDX];
    assign v = flags_i[V_IDX];

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// branch_cond_unit: banked NZCV flag store plus branch condition resolver.
//   clk, rst        : clock, synchronous active-high reset
//   flag_we         : write flags_in into bank flag_bank (any FSM state)
//   flag_bank       : target bank; indices >= NUM_BANKS are ignored
//   flags_in        : {N,Z,C,V}
//   flags_o         : contents of bank br_bank (combinational read)
//   br              : branch handshake/result interface (slave modport)
// A branch accepted in cycle T reports taken_valid_o/taken_o in T+1; a taken
// branch then holds flush_o for FLUSH_CYCLES cycles before the next accept.
// Build option FLAG_BYPASS_EN: a same-cycle flag write to bank br_bank is
// forwarded into the evaluation and flags_o (the bank still updates).
// ---------------------------------------------------------------------------
module branch_cond_unit
    import cond_pkg::*;
#(
    parameter int NUM_BANKS    = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int BANK_W       = calc_bank_w(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic [BANK_W-1:0] flag_bank,
    input  logic [3:0]        flags_in,
    output logic [3:0]        flags_o,
    branch_cond_unit_if.slave br
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    // ------------------------------------------------------------------ banks
    logic [3:0] bank_flags [NUM_BANKS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [3:0] flags_q, flags_d;

            always_comb begin
                flags_d = flags_q;
                if (flag_we && (flag_bank == BANK_W'(gi)))
                    flags_d = flags_in;
            end

            always_ff @(posedge clk) begin
                if (rst) flags_q <= 4'b0000;
                else     flags_q <= flags_d;
            end

            assign bank_flags[gi] = flags_q;
        end
    endgenerate

    // Read mux; an out-of-range br_bank reads as zero flags.
    logic [3:0] rd_flags;
    always_comb begin
        rd_flags = 4'b0000;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (br.br_bank == BANK_W'(i))
                rd_flags = bank_flags[i];
        end
`ifdef FLAG_BYPASS_EN
        if (flag_we && (flag_bank == br.br_bank))
            rd_flags = flags_in;
`endif
    end

    assign flags_o = rd_flags;

    // -------------------------------------------------------------- evaluate
    logic cond_pass;

    cond_eval u_cond_eval (
        .cond_i  (cond_e'(br.br_cond)),
        .flags_i (rd_flags),
        .pass_o  (cond_pass)
    );

    // ------------------------------------------------------------------- FSM
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             taken_valid_q, taken_valid_d;
    logic             taken_q, taken_d;
    logic             flush_q, flush_d;
    logic             accept;

    // Ready is forced low during reset so nothing is accepted on that edge.
    assign br.br_ready = (state_q == IDLE) & ~rst;
    assign accept      = br.br_valid & br.br_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        taken_valid_d = 1'b0;
        taken_d       = 1'b0;
        flush_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = RESOLVE;
                    taken_valid_d = 1'b1;
                    taken_d       = cond_pass & br.wpc_en;
                end
            end
            RESOLVE: begin
                if (taken_q && (FLUSH_CYCLES > 0)) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    flush_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                // flush_o is registered, so it is raised for the next cycle
                // only while more flush cycles remain.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            taken_valid_q <= 1'b0;
            taken_q       <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            taken_valid_q <= taken_valid_d;
            taken_q       <= taken_d;
            flush_q       <= flush_d;
        end
    end

    assign br.taken_valid_o = taken_valid_q;
    assign br.taken_o       = taken_q;
    assign br.flush_o       = flush_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_cond_unit: directed bench for branch_cond_unit.
// dut_a: NUM_BANKS=2, FLUSH_CYCLES=2 (default build).
// dut_b: NUM_BANKS=4, FLUSH_CYCLES=0 (no flush state, back-to-back accepts).
// ---------------------------------------------------------------------------
module tb_branch_cond_unit;
    import cond_pkg::*;

`ifdef FLAG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int A_FC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------- DUT A
    logic       a_flag_we;
    logic [0:0] a_flag_bank;
    logic [3:0] a_flags_in, a_flags_o;
    branch_cond_unit_if #(.BANK_W(1)) a_if ();

    branch_cond_unit #(.NUM_BANKS(2), .FLUSH_CYCLES(A_FC)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .flag_we   (a_flag_we),
        .flag_bank (a_flag_bank),
        .flags_in  (a_flags_in),
        .flags_o   (a_flags_o),
        .br        (a_if)
    );

    // ------------------------------------------------------------- DUT B
    logic       b_flag_we;
    logic [1:0] b_flag_bank;
    logic [3:0] b_flags_in, b_flags_o;
    branch_cond_unit_if #(.BANK_W(2)) b_if ();

    branch_cond_unit #(.NUM_BANKS(4), .FLUSH_CYCLES(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .flag_we   (b_flag_we),
        .flag_bank (b_flag_bank),
        .flags_in  (b_flags_in),
        .flags_o   (b_flags_o),
        .br        (b_if)
    );

    // ----------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic bank, input logic [3:0] f);
        a_flag_we   = 1'b1;
        a_flag_bank = bank;
        a_flags_in  = f;
        step();
        a_flag_we   = 1'b0;
        a_flags_in  = ~f;
    endtask

    task automatic write_b(input logic [1:0] bank, input logic [3:0] f);
        b_flag_we   = 1'b1;
        b_flag_bank = bank;
        b_flags_in  = f;
        step();
        b_flag_we   = 1'b0;
    endtask

    task automatic wait_ready_a(input string name);
        int n = 0;
        while (!a_if.br_ready && n < 20) begin
            step();
            n++;
        end
        check({name, " ready"}, a_if.br_ready, 1);
    endtask

    // Full branch transaction on dut_a including flush/ready timing.
    task automatic branch_a(input logic [3:0] cond, input logic bank, input logic wpc,
                            input logic exp_taken, input string name);
        wait_ready_a(name);
        a_if.br_valid = 1'b1;
        a_if.br_cond  = cond;
        a_if.br_bank  = bank;
        a_if.wpc_en   = wpc;
        step();                                   // accept edge T
        a_if.br_valid = 1'b0;
        a_if.br_cond  = ~cond;                    // payload may change freely now
        a_if.wpc_en   = ~wpc;
        check({name, " tv"},    a_if.taken_valid_o, 1);
        check({name, " taken"}, a_if.taken_o,       exp_taken);
        check({name, " busy"},  a_if.br_ready,      0);
        step();                                   // T+2
        if (exp_taken) begin
            for (int k = 0; k < A_FC; k++) begin
                check({name, " flush"},  a_if.flush_o,  1);
                check({name, " fbusy"},  a_if.br_ready, 0);
                step();
            end
        end
        check({name, " noflush"}, a_if.flush_o,       0);
        check({name, " rdy"},     a_if.br_ready,      1);
        check({name, " notv"},    a_if.taken_valid_o, 0);
        $display("txn %s cond=%0d bank=%0d wpc=%0b taken=%0b", name, cond, bank, wpc, exp_taken);
    endtask

    typedef struct {
        logic       wbank;
        logic [3:0] wflags;
        logic [3:0] cond;
        logic       bank;
        logic       wpc;
        logic       exp_taken;
    } vec_t;

    vec_t vecs [18];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 4'b0100, 4'd0,  1'b0, 1'b1, 1'b1};  // EQ Z=1
        vecs[1]  = '{1'b1, 4'b1001, 4'd10, 1'b1, 1'b1, 1'b1};  // GE N=V
        vecs[2]  = '{1'b1, 4'b1001, 4'd11, 1'b1, 1'b1, 1'b0};  // LT
        vecs[3]  = '{1'b0, 4'b0100, 4'd15, 1'b0, 1'b1, 1'b0};  // NV
        vecs[4]  = '{1'b0, 4'b0100, 4'd14, 1'b0, 1'b0, 1'b0};  // AL, wpc=0
        vecs[5]  = '{1'b0, 4'b0100, 4'd14, 1'b0, 1'b1, 1'b1};  // AL
        vecs[6]  = '{1'b1, 4'b0010, 4'd8,  1'b1, 1'b1, 1'b1};  // HI C&!Z
        vecs[7]  = '{1'b1, 4'b0110, 4'd9,  1'b1, 1'b1, 1'b1};  // LS
        vecs[8]  = '{1'b0, 4'b0000, 4'd12, 1'b0, 1'b1, 1'b1};  // GT
        vecs[9]  = '{1'b0, 4'b1000, 4'd13, 1'b0, 1'b1, 1'b1};  // LE N!=V
        vecs[10] = '{1'b0, 4'b0001, 4'd6,  1'b0, 1'b1, 1'b1};  // VS
        vecs[11] = '{1'b0, 4'b0001, 4'd5,  1'b0, 1'b1, 1'b1};  // PL
        vecs[12] = '{1'b0, 4'b1000, 4'd4,  1'b0, 1'b1, 1'b1};  // MI
        vecs[13] = '{1'b0, 4'b1000, 4'd3,  1'b0, 1'b1, 1'b1};  // CC
        vecs[14] = '{1'b0, 4'b0100, 4'd1,  1'b0, 1'b1, 1'b0};  // NE with Z=1
        vecs[15] = '{1'b1, 4'b0010, 4'd2,  1'b0, 1'b1, 1'b0};  // CS on bank0 (C=0), bank1 has C=1
        vecs[16] = '{1'b1, 4'b0001, 4'd7,  1'b1, 1'b1, 1'b0};  // VC with V=1
        vecs[17] = '{1'b0, 4'b0110, 4'd8,  1'b0, 1'b1, 1'b0};  // HI with Z=1

        rst = 1'b1;
        a_flag_we = 1'b0; a_flag_bank = '0; a_flags_in = '0;
        a_if.br_valid = 1'b0; a_if.br_cond = '0; a_if.br_bank = '0; a_if.wpc_en = 1'b0;
        b_flag_we = 1'b0; b_flag_bank = '0; b_flags_in = '0;
        b_if.br_valid = 1'b0; b_if.br_cond = '0; b_if.br_bank = '0; b_if.wpc_en = 1'b0;

        // ---------------------------------------------------------- reset
        step();
        step();
        check("rst ready_a", a_if.br_ready, 0);
        check("rst ready_b", b_if.br_ready, 0);
        rst = 1'b0;
        #1;
        check("rst ready_a_after", a_if.br_ready,      1);
        check("rst tv",            a_if.taken_valid_o, 0);
        check("rst taken",         a_if.taken_o,       0);
        check("rst flush",         a_if.flush_o,       0);
        check("rst flags0",        a_flags_o,          4'b0000);
        a_if.br_bank = 1'b1;
        #1;
        check("rst flags1",        a_flags_o,          4'b0000);
        $display("txn reset done");

        // ------------------------------------------------------- vectors
        for (int i = 0; i < 18; i++) begin
            write_a(vecs[i].wbank, vecs[i].wflags);
            a_if.br_bank = vecs[i].wbank;
            #1;
            check($sformatf("vec%0d flags_o", i), a_flags_o, vecs[i].wflags);
            branch_a(vecs[i].cond, vecs[i].bank, vecs[i].wpc, vecs[i].exp_taken,
                     $sformatf("vec%0d", i));
        end

        // ------------------------------ same-cycle flag write + accept
        write_a(1'b0, 4'b0000);
        wait_ready_a("byp");
        a_if.br_bank  = 1'b0;
        a_flag_we     = 1'b1;
        a_flag_bank   = 1'b0;
        a_flags_in    = 4'b0100;
        a_if.br_valid = 1'b1;
        a_if.br_cond  = 4'd0;
        a_if.wpc_en   = 1'b1;
        #1;
        check("byp flags_o", a_flags_o, BYP ? 4'b0100 : 4'b0000);
        step();
        a_flag_we     = 1'b0;
        a_if.br_valid = 1'b0;
        check("byp tv",    a_if.taken_valid_o, 1);
        check("byp taken", a_if.taken_o,       BYP);
        check("byp bank",  a_flags_o,          4'b0100);
        $display("txn bypass EQ bank0 taken=%0b", a_if.taken_o);
        wait_ready_a("byp end");

        // ------------------------------------------- reset during FLUSH
        a_if.br_valid = 1'b1;
        a_if.br_cond  = 4'd14;
        a_if.br_bank  = 1'b0;
        a_if.wpc_en   = 1'b1;
        step();
        a_if.br_valid = 1'b0;
        check("rstfl taken", a_if.taken_o, 1);
        step();
        check("rstfl flush1", a_if.flush_o, 1);
        rst = 1'b1;
        #1;
        check("rstfl ready_in_rst", a_if.br_ready, 0);
        step();
        check("rstfl flush", a_if.flush_o,       0);
        check("rstfl tv",    a_if.taken_valid_o, 0);
        check("rstfl flags", a_flags_o,          4'b0000);
        rst = 1'b0;
        #1;
        check("rstfl idle", a_if.br_ready, 1);
        $display("txn reset during flush");

        // ------------------------------- dut_b: 4 banks, no flush state
        write_b(2'd3, 4'b0100);
        write_b(2'd0, 4'b1001);
        b_if.br_bank = 2'd3;
        #1;
        check("b flags3", b_flags_o, 4'b0100);
        b_if.br_bank = 2'd0;
        #1;
        check("b flags0", b_flags_o, 4'b1001);
        b_if.br_valid = 1'b1;
        b_if.br_cond  = 4'd0;
        b_if.br_bank  = 2'd3;
        b_if.wpc_en   = 1'b1;
        #1;
        check("b ready", b_if.br_ready, 1);
        step();                                   // accept T on bank3
        check("b1 tv",    b_if.taken_valid_o, 1);
        check("b1 taken", b_if.taken_o,       1);
        check("b1 busy",  b_if.br_ready,      0);
        check("b1 flush", b_if.flush_o,       0);
        b_if.br_bank = 2'd0;                      // valid held high
        step();
        check("b2 noflush", b_if.flush_o,       0);
        check("b2 ready",   b_if.br_ready,      1);
        check("b2 notv",    b_if.taken_valid_o, 0);
        $display("txn b EQ bank3 taken=1");
        step();                                   // accept T+2 on bank0
        b_if.br_valid = 1'b0;
        check("b3 tv",    b_if.taken_valid_o, 1);
        check("b3 taken", b_if.taken_o,       0);
        step();
        check("b4 ready", b_if.br_ready,      1);
        check("b4 notv",  b_if.taken_valid_o, 0);
        check("b4 flush", b_if.flush_o,       0);
        $display("txn b EQ bank0 taken=0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
